// File: rtl/pc_pkg.sv
// Shared select encodings and PC type for the fetch-stage next-PC selector.
package pc_pkg;

  localparam int unsigned PC_AW = 5;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_BR  = 1'b1;

  typedef logic [PC_AW-1:0] pc_t;

endpackage

// File: rtl/mux2.sv
// Width-parameterized 2:1 combinational multiplexer; an unknown select yields all-X.
module mux2 #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  import pc_pkg::*;

  always_comb begin
    y = 'x;
    case (sel)
      PC_SEL_SEQ: y = a;
      PC_SEL_BR:  y = b;
      default:    y = 'x;
    endcase
  end

endmodule

// File: rtl/pc_src_select.sv
// Next-PC source selector with registered PC. Define PC_SRC_CNT_EN to add a
// wrapping taken-branch counter (taken_cnt).
module pc_src_select
  import pc_pkg::*;
#(
  parameter int unsigned    AW     = PC_AW,
  parameter logic [AW-1:0]  RST_PC = '0,
  parameter int unsigned    CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    in_adder1,
  input  logic [AW-1:0]    in_adder2,
  input  logic             cntrl_pc_src,
  input  logic             stall,
`ifdef PC_SRC_CNT_EN
  output logic [CNT_W-1:0] taken_cnt,
`endif
  output logic [AW-1:0]    out_pc,
  output logic [AW-1:0]    pc_q
);

  logic [AW-1:0] pc_d;

  mux2 #(
    .W (AW)
  ) u_mux2 (
    .a   (in_adder1),
    .b   (in_adder2),
    .sel (cntrl_pc_src),
    .y   (out_pc)
  );

  always_comb begin
    pc_d = pc_q;
    if (!stall) pc_d = out_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RST_PC;
    else     pc_q <= pc_d;
  end

`ifdef PC_SRC_CNT_EN
  logic [CNT_W-1:0] taken_cnt_d;

  // Counts only edges that actually load a branch target.
  always_comb begin
    taken_cnt_d = taken_cnt;
    if (!stall && (cntrl_pc_src == PC_SEL_BR)) taken_cnt_d = taken_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) taken_cnt <= '0;
    else     taken_cnt <= taken_cnt_d;
  end
`endif

endmodule

// File: tb/tb_pc_src_select.sv
// Directed self-checking bench for pc_src_select (optionally with PC_SRC_CNT_EN).
module tb_pc_src_select;
  import pc_pkg::*;

  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] in_adder1;
  logic [AW-1:0] in_adder2;
  logic          cntrl_pc_src;
  logic          stall;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] pc_q;
`ifdef PC_SRC_CNT_EN
  logic [CNT_W-1:0] taken_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pc_src_select #(
    .AW     (AW),
    .RST_PC ('0),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_adder1    (in_adder1),
    .in_adder2    (in_adder2),
    .cntrl_pc_src (cntrl_pc_src),
    .stall        (stall),
`ifdef PC_SRC_CNT_EN
    .taken_cnt    (taken_cnt),
`endif
    .out_pc       (out_pc),
    .pc_q         (pc_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    stall        = 1'b0;
    cntrl_pc_src = PC_SEL_SEQ;
    in_adder1    = 5'b01000;
    in_adder2    = 5'b00110;
    #1;
    check("reset_pc", 32'(pc_q), 32'h0);
    check("comb_sel0_a", 32'(out_pc), 32'b01000);
    #19;
    cntrl_pc_src = PC_SEL_BR;
    in_adder1    = 5'b00100;
    in_adder2    = 5'b01010;
    #1;
    check("comb_sel1", 32'(out_pc), 32'b01010);
    #19;
    cntrl_pc_src = PC_SEL_SEQ;
    in_adder1    = 5'b00010;
    in_adder2    = 5'b00000;
    #1;
    check("comb_sel0_b", 32'(out_pc), 32'b00010);
    check("reset_hold_pc", 32'(pc_q), 32'h0);

    // Reset release, first load, then async reset between edges.
    tick();
    rst       = 1'b0;
    in_adder1 = 5'b00011;
    tick();
    check("first_load_seq", 32'(pc_q), 32'b00011);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'(pc_q), 32'h0);
    #1;
    rst          = 1'b0;
    cntrl_pc_src = PC_SEL_BR;
    in_adder2    = 5'b01010;
    tick();
    check("load_after_reset", 32'(pc_q), 32'b01010);

    // Stall holds across select and input changes.
    cntrl_pc_src = PC_SEL_SEQ;
    in_adder1    = 5'b00100;
    tick();
    check("pre_stall_load", 32'(pc_q), 32'b00100);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cntrl_pc_src = ~cntrl_pc_src;
      in_adder1    = 5'(i + 7);
      in_adder2    = 5'(i + 20);
      tick();
      check($sformatf("stall_hold_%0d", i), 32'(pc_q), 32'b00100);
    end
    stall        = 1'b0;
    cntrl_pc_src = PC_SEL_BR;
    in_adder2    = 5'b10001;
    tick();
    check("unstall_load", 32'(pc_q), 32'b10001);

    // Reset while stalled acts immediately.
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("reset_in_stall", 32'(pc_q), 32'h0);
`ifdef PC_SRC_CNT_EN
    check("cnt_reset", 32'(taken_cnt), 32'h0);
`endif
    #1;
    rst   = 1'b0;
    stall = 1'b0;

`ifdef PC_SRC_CNT_EN
    cntrl_pc_src = PC_SEL_BR;
    repeat (5) tick();
    check("cnt_wrap", 32'(taken_cnt), 32'h1);
    stall = 1'b1;
    tick();
    check("cnt_stall_hold", 32'(taken_cnt), 32'h1);
    stall        = 1'b0;
    cntrl_pc_src = PC_SEL_SEQ;
    tick();
    check("cnt_seq_hold", 32'(taken_cnt), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("cnt_async_reset", 32'(taken_cnt), 32'h0);
    #1;
    rst = 1'b0;
`endif

    // Equal inputs give the same output for either select.
    in_adder1    = 5'b11111;
    in_adder2    = 5'b11111;
    cntrl_pc_src = PC_SEL_SEQ;
    #1;
    check("equal_sel0", 32'(out_pc), 32'b11111);
    cntrl_pc_src = PC_SEL_BR;
    #1;
    check("equal_sel1", 32'(out_pc), 32'b11111);
    tick();
    check("equal_pc_load", 32'(pc_q), 32'b11111);
    cntrl_pc_src = PC_SEL_SEQ;
    #1;
    check("equal_sel0_again", 32'(out_pc), 32'b11111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
